score_ctrl: RTL and testbench

SCORE_CTRL -- requirements
Module: score_ctrl

---
 rtl/score_ctrl_pkg.sv | 18 +
 rtl/score_ctrl_if.sv | 25 ++
 rtl/score_ctrl_bcd_counter.sv | 22 ++
 rtl/score_ctrl.sv | 149 ++++++++++++++
 tb/tb_score_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/score_ctrl_pkg.sv
// Shared types and defaults for the score controller slice.
package score_pkg;

   typedef enum logic [1:0] {
      ST_PLAY = 2'd0,
      ST_HOLD = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   localparam int WIN_COUNT_DEF    = 7;
   localparam int HOLD_CYCLES_DEF  = 8;
   localparam int BLINK_CYCLES_DEF = 2;

endpackage

// File: rtl/score_ctrl_if.sv
// Game-event inputs and scoreboard outputs of score_ctrl, bundled for port hookup.
interface score_ctrl_if;

   logic       p1_win;
   logic       p2_win;
   logic       clr_game;
   logic [3:0] bcd1;
   logic [3:0] bcd0;
   logic       blank1;
   logic       blank0;
   logic       round_reset;
   logic       game_over;
   logic [1:0] winner;

   modport master (
      output p1_win, p2_win, clr_game,
      input  bcd1, bcd0, blank1, blank0, round_reset, game_over, winner
   );

   modport slave (
      input  p1_win, p2_win, clr_game,
      output bcd1, bcd0, blank1, blank0, round_reset, game_over, winner
   );

endinterface

// File: rtl/score_ctrl_bcd_counter.sv
// Single-digit BCD counter with synchronous clear and saturation at MAX (MAX <= 9).
module bcd_counter
   import score_pkg::*;
#(
   parameter int MAX = WIN_COUNT_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] q
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         q <= 4'd0;
      end else if (inc && (q < 4'(MAX))) begin
         q <= q + 4'd1;
      end
   end

endmodule

// File: rtl/score_ctrl.sv
// Two-player score/round controller: scoring, post-round hold, game end and new-game clear.
// Define SCORE_CTRL_BLINK_EN to blink the round winner's digit during the hold.
module score_ctrl
   import score_pkg::*;
#(
   parameter int WIN_COUNT    = WIN_COUNT_DEF,
   parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
   parameter int BLINK_CYCLES = BLINK_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   score_ctrl_if.slave bus
);

   state_t      state_q, state_d;
   logic [15:0] hold_q, hold_d;
   logic        round_reset_q, round_reset_d;
   logic        game_over_q, game_over_d;
   logic [1:0]  winner_q, winner_d;
   logic [3:0]  bcd1, bcd0;
   logic        accept, win1, win2, final1, final2;

   // A win only counts in PLAY, outside the restart cycle and when no clear is pending.
   assign accept = (state_q == ST_PLAY) && !round_reset_q && !bus.clr_game;
   assign win1   = accept && bus.p1_win && !bus.p2_win;
   assign win2   = accept && bus.p2_win && !bus.p1_win;
   assign final1 = win1 && (bcd1 == 4'(WIN_COUNT - 1));
   assign final2 = win2 && (bcd0 == 4'(WIN_COUNT - 1));

   bcd_counter #(.MAX(WIN_COUNT)) u_score1 (
      .clk   (clk),
      .reset (reset),
      .clr   (bus.clr_game),
      .inc   (win1),
      .q     (bcd1)
   );

   bcd_counter #(.MAX(WIN_COUNT)) u_score0 (
      .clk   (clk),
      .reset (reset),
      .clr   (bus.clr_game),
      .inc   (win2),
      .q     (bcd0)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_PLAY;
         hold_q        <= '0;
         round_reset_q <= 1'b0;
         game_over_q   <= 1'b0;
         winner_q      <= WIN_NONE;
      end else begin
         state_q       <= state_d;
         hold_q        <= hold_d;
         round_reset_q <= round_reset_d;
         game_over_q   <= game_over_d;
         winner_q      <= winner_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      if (bus.clr_game) begin
         state_d = ST_PLAY;
         hold_d  = '0;
      end else begin
         case (state_q)
            ST_PLAY: begin
               if (final1 || final2) begin
                  state_d = ST_OVER;
               end else if (win1 || win2) begin
                  state_d = ST_HOLD;
                  hold_d  = 16'(HOLD_CYCLES - 1);
               end
            end
            ST_HOLD: begin
               if (hold_q == '0) begin
                  state_d = ST_PLAY;
               end else begin
                  hold_d = hold_q - 16'd1;
               end
            end
            ST_OVER: state_d = ST_OVER;
            default: state_d = ST_PLAY;
         endcase
      end
   end

   always_comb begin
      round_reset_d = bus.clr_game || ((state_q == ST_HOLD) && (hold_q == '0));
      game_over_d   = (state_d == ST_OVER);
      winner_d      = winner_q;
      if (bus.clr_game) begin
         winner_d = WIN_NONE;
      end else if (final1) begin
         winner_d = WIN_P1;
      end else if (final2) begin
         winner_d = WIN_P2;
      end
   end

   assign bus.bcd1        = bcd1;
   assign bus.bcd0        = bcd0;
   assign bus.round_reset = round_reset_q;
   assign bus.game_over   = game_over_q;
   assign bus.winner      = winner_q;

`ifdef SCORE_CTRL_BLINK_EN
   logic [15:0] blink_q;
   logic        rnd_p1_q;
   logic        blank1_q, blank0_q;

   // Winner's digit starts dark on the first hold cycle, then toggles every BLINK_CYCLES.
   always_ff @(posedge clk) begin
      if (reset || bus.clr_game) begin
         blink_q  <= '0;
         rnd_p1_q <= 1'b0;
         blank1_q <= 1'b0;
         blank0_q <= 1'b0;
      end else if ((state_q == ST_PLAY) && (state_d == ST_HOLD)) begin
         blink_q  <= 16'(BLINK_CYCLES - 1);
         rnd_p1_q <= win1;
         blank1_q <= win1;
         blank0_q <= win2;
      end else if (state_d == ST_HOLD) begin
         if (blink_q == '0) begin
            blink_q  <= 16'(BLINK_CYCLES - 1);
            blank1_q <= rnd_p1_q ? ~blank1_q : 1'b0;
            blank0_q <= rnd_p1_q ? 1'b0 : ~blank0_q;
         end else begin
            blink_q <= blink_q - 16'd1;
         end
      end else begin
         blink_q  <= '0;
         blank1_q <= 1'b0;
         blank0_q <= 1'b0;
      end
   end

   assign bus.blank1 = blank1_q;
   assign bus.blank0 = blank0_q;
`else
   assign bus.blank1 = 1'b0;
   assign bus.blank0 = 1'b0;
`endif

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl: cycle vector table plus hand-written game sequences.
module tb_score_ctrl;
   import score_pkg::*;

`ifdef SCORE_CTRL_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   score_ctrl_if bus();

   score_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, p1, p2, clr;
      logic [3:0] b1, b0;
      logic       bl1, bl0, rr, go;
      logic [1:0] win;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst, p1, p2, clr, input logic [3:0] b1, b0,
                      input logic bl1, bl0, rr, go, input logic [1:0] win);
      vec_t v;
      v = '{rst, p1, p2, clr, b1, b0, bl1, bl0, rr, go, win};
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Drive inputs away from the edge, then sample just after it.
   task automatic step(input logic rst, p1, p2, clr);
      @(negedge clk);
      reset        = rst;
      bus.p1_win   = p1;
      bus.p2_win   = p2;
      bus.clr_game = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rr(input int limit, input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         if (bus.round_reset) seen = 1'b1;
      end
      chk(nm, {31'd0, seen}, 32'd1);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      reset        = 1'b1;
      bus.p1_win   = 1'b0;
      bus.p2_win   = 1'b0;
      bus.clr_game = 1'b0;

      //  rst p1 p2 clr  b1 b0 bl1 bl0 rr go win
      add(1, 1, 0, 1,  0, 0, 0, 0, 0, 0, 2'b00);  // reset beats clr and win
      add(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'b00);
      add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'b00);
      add(0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 2'b00);  // tie
      add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'b00);
      add(0, 1, 0, 0,  1, 0, BLINK, 0, 0, 0, 2'b00);  // hold cycle 1
      add(0, 0, 0, 0,  1, 0, BLINK, 0, 0, 0, 2'b00);
      add(0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 2'b00);  // win during hold ignored
      add(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 2'b00);
      add(0, 0, 0, 0,  1, 0, BLINK, 0, 0, 0, 2'b00);
      add(0, 0, 0, 0,  1, 0, BLINK, 0, 0, 0, 2'b00);
      add(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 2'b00);
      add(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 2'b00);  // hold cycle 8
      add(0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 2'b00);  // round_reset
      add(0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 2'b00);  // win during round_reset ignored
      add(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 2'b00);
      add(0, 0, 1, 0,  1, 1, 0, BLINK, 0, 0, 2'b00);
      add(0, 0, 0, 0,  1, 1, 0, BLINK, 0, 0, 2'b00);
      add(0, 0, 1, 1,  0, 0, 0, 0, 1, 0, 2'b00);  // clr in hold beats win
      add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'b00);
      add(0, 1, 0, 0,  1, 0, BLINK, 0, 0, 0, 2'b00);
      add(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'b00);  // reset mid-hold
      add(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'b00);  // no round_reset afterwards
      add(0, 0, 1, 0,  0, 1, 0, BLINK, 0, 0, 2'b00);
      add(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'b00);

      foreach (vq[i]) begin
         step(vq[i].rst, vq[i].p1, vq[i].p2, vq[i].clr);
         chk($sformatf("vec%0d.bcd1", i), 32'(bus.bcd1), 32'(vq[i].b1));
         chk($sformatf("vec%0d.bcd0", i), 32'(bus.bcd0), 32'(vq[i].b0));
         chk($sformatf("vec%0d.blank1", i), 32'(bus.blank1), 32'(vq[i].bl1));
         chk($sformatf("vec%0d.blank0", i), 32'(bus.blank0), 32'(vq[i].bl0));
         chk($sformatf("vec%0d.round_reset", i), 32'(bus.round_reset), 32'(vq[i].rr));
         chk($sformatf("vec%0d.game_over", i), 32'(bus.game_over), 32'(vq[i].go));
         chk($sformatf("vec%0d.winner", i), 32'(bus.winner), 32'(vq[i].win));
      end

      // Player 2 wins seven rounds; the seventh goes straight to OVER.
      for (int k = 1; k <= WIN_COUNT_DEF; k++) begin
         if (k > 1) wait_rr(20, $sformatf("p2run%0d.wait_round_reset", k));
         step(1'b0, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b1, 1'b0);
         chk($sformatf("p2run%0d.bcd0", k), 32'(bus.bcd0), 32'(k));
         chk($sformatf("p2run%0d.bcd1", k), 32'(bus.bcd1), 32'd0);
         chk($sformatf("p2run%0d.game_over", k), 32'(bus.game_over),
             (k == WIN_COUNT_DEF) ? 32'd1 : 32'd0);
         chk($sformatf("p2run%0d.blank0", k), 32'(bus.blank0),
             (k == WIN_COUNT_DEF) ? 32'd0 : 32'(BLINK));
      end
      chk("over.winner", 32'(bus.winner), 32'(WIN_P2));

      begin
         int rr_seen, bad_over;
         rr_seen  = 0;
         bad_over = 0;
         for (int i = 0; i < 12; i++) begin
            step(1'b0, (i == 3), (i == 5), 1'b0);
            if (bus.round_reset) rr_seen++;
            if (!bus.game_over || bus.winner != WIN_P2 || bus.blank0 || bus.blank1) bad_over++;
         end
         chk("over.no_round_reset", 32'(rr_seen), 32'd0);
         chk("over.steady", 32'(bad_over), 32'd0);
         chk("over.bcd0_frozen", 32'(bus.bcd0), 32'd7);
         chk("over.bcd1_frozen", 32'(bus.bcd1), 32'd0);
      end

      // New game from OVER, clear wins over a simultaneous p1 pulse.
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk("clr.bcd1", 32'(bus.bcd1), 32'd0);
      chk("clr.bcd0", 32'(bus.bcd0), 32'd0);
      chk("clr.game_over", 32'(bus.game_over), 32'd0);
      chk("clr.winner", 32'(bus.winner), 32'(WIN_NONE));
      chk("clr.round_reset", 32'(bus.round_reset), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("clr.round_reset_end", 32'(bus.round_reset), 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("newgame.bcd1", 32'(bus.bcd1), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
